// File: rtl/pc_stall_ctrl.sv
// Hazard/stall scheduler for the fetch front end.
// Combines load-use, ID-stage branch operand, instruction-fetch wait and
// multi-cycle MDU hazards into one stall that freezes the PC and the IF/ID
// register and inserts a bubble into ID/EX. It also tracks MDU occupancy
// and keeps a saturating count of stall cycles.
module pc_stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ImemReady,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic        UseRsD,
    input  logic        UseRtD,
    input  logic        IsBrD,
    input  logic        RegWriteE,
    input  logic        MemToRegE,
    input  logic [4:0]  WriteRegE,
    input  logic        MemToRegM,
    input  logic [4:0]  WriteRegM,
    input  logic        MduStartE,
    input  logic        MduIsDivE,
    input  logic        MduReadD,
    output logic        PCEn,
    output logic        FDEn,
    output logic        DEClr,
    output logic        MduBusy,
    output logic        MduErr,
    output logic [31:0] StallCnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    // Counter load values; the 1..255 parameter range fits in 8 bits.
    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES);

    mdu_state_t  state;
    logic [7:0]  cnt;
    logic        busy_r;
    logic        err_r;
    logic [31:0] stall_cnt;

    logic        match_e;
    logic        match_m;
    logic        haz_lu;
    logic        haz_br;
    logic        haz_fw;
    logic        haz_md;
    logic        stall;

    // Saturating increment: the stall counter sticks at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // True when the ID instruction reads register r; r0 never matches.
    function automatic logic reg_match(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt
    );
        return (r != 5'd0) && ((use_rs && (rs == r)) || (use_rt && (rt == r)));
    endfunction

    // Hazard detection: every source is independent and simply ORed.
    always_comb begin
        match_e = reg_match(WriteRegE, RsD, RtD, UseRsD, UseRtD);
        match_m = reg_match(WriteRegM, RsD, RtD, UseRsD, UseRtD);
        haz_lu  = MemToRegE && RegWriteE && match_e;
        haz_br  = IsBrD && ((RegWriteE && match_e) || (MemToRegM && match_m));
        haz_fw  = !ImemReady;
        haz_md  = MduReadD && (busy_r || MduStartE);
        stall   = haz_lu || haz_br || haz_fw || haz_md;
    end

    // Pipeline controls; reset freezes fetch and keeps a bubble in ID/EX.
    always_comb begin
        PCEn  = 1'b0;
        FDEn  = 1'b0;
        DEClr = 1'b1;
        if (!rst) begin
            PCEn  = !stall;
            FDEn  = !stall;
            DEClr = stall;
        end
    end

    // MDU occupancy FSM; runs freely regardless of pipeline stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            busy_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MduStartE) begin
                        state  <= BUSY;
                        cnt    <= MduIsDivE ? DIV_LOAD : MULT_LOAD;
                        busy_r <= 1'b1;
                    end
                end
                BUSY: begin
                    // A start while occupied is dropped and flagged.
                    if (MduStartE) begin
                        err_r <= 1'b1;
                    end
                    if (cnt == 8'd1) begin
                        state  <= IDLE;
                        cnt    <= 8'd0;
                        busy_r <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= 8'd0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign MduBusy  = busy_r;
    assign MduErr   = err_r;
    assign StallCnt = stall_cnt;

endmodule

// File: tb/tb_pc_stall_ctrl.sv
// Testbench for pc_stall_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the stall rules.
module tb_pc_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ImemReady = 1'b1;
    logic [4:0]  RsD = '0;
    logic [4:0]  RtD = '0;
    logic        UseRsD = 1'b0;
    logic        UseRtD = 1'b0;
    logic        IsBrD = 1'b0;
    logic        RegWriteE = 1'b0;
    logic        MemToRegE = 1'b0;
    logic [4:0]  WriteRegE = '0;
    logic        MemToRegM = 1'b0;
    logic [4:0]  WriteRegM = '0;
    logic        MduStartE = 1'b0;
    logic        MduIsDivE = 1'b0;
    logic        MduReadD = 1'b0;
    logic        PCEn;
    logic        FDEn;
    logic        DEClr;
    logic        MduBusy;
    logic        MduErr;
    logic [31:0] StallCnt;

    int checks = 0;
    int passed = 0;

    // Model state: remaining busy cycles, sticky error, stall count.
    int          m_rem = 0;
    bit          m_err = 1'b0;
    logic [31:0] m_cnt = 32'd0;
    bit          sat_load = 1'b0;

    pc_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst(rst), .ImemReady(ImemReady),
        .RsD(RsD), .RtD(RtD), .UseRsD(UseRsD), .UseRtD(UseRtD),
        .IsBrD(IsBrD), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
        .WriteRegE(WriteRegE), .MemToRegM(MemToRegM), .WriteRegM(WriteRegM),
        .MduStartE(MduStartE), .MduIsDivE(MduIsDivE), .MduReadD(MduReadD),
        .PCEn(PCEn), .FDEn(FDEn), .DEClr(DEClr),
        .MduBusy(MduBusy), .MduErr(MduErr), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit reads(input logic [4:0] r);
        return (r != 5'd0) && ((UseRsD && RsD == r) || (UseRtD && RtD == r));
    endfunction

    // Stall decision straight from the hazard rules.
    function automatic bit model_stall();
        bit lu, br, fw, md;
        lu = MemToRegE && RegWriteE && reads(WriteRegE);
        br = IsBrD && ((RegWriteE && reads(WriteRegE)) || (MemToRegM && reads(WriteRegM)));
        fw = !ImemReady;
        md = MduReadD && ((m_rem > 0) || MduStartE);
        return lu || br || fw || md;
    endfunction

    // Model update at each edge, compare half a cycle later.
    always begin
        bit s;
        @(posedge clk);
        s = model_stall();
        if (rst) begin
            m_rem = 0;
            m_err = 1'b0;
            m_cnt = 32'd0;
        end else begin
            if (s && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (m_rem > 0) begin
                if (MduStartE) m_err = 1'b1;
                m_rem = m_rem - 1;
            end else if (MduStartE) begin
                m_rem = MduIsDivE ? DIV_N : MULT_N;
            end
        end
        @(negedge clk);
        #2;
        if (sat_load) m_cnt = 32'hFFFF_FFFE;
        s = model_stall();
        chk("PCEn",     {31'd0, PCEn},    rst ? 32'd0 : {31'd0, !s});
        chk("FDEn",     {31'd0, FDEn},    rst ? 32'd0 : {31'd0, !s});
        chk("DEClr",    {31'd0, DEClr},   rst ? 32'd1 : {31'd0, s});
        chk("MduBusy",  {31'd0, MduBusy}, {31'd0, m_rem > 0});
        chk("MduErr",   {31'd0, MduErr},  {31'd0, m_err});
        chk("StallCnt", StallCnt,         m_cnt);
    end

    task automatic idle_inputs();
        ImemReady = 1'b1; RsD = '0; RtD = '0; UseRsD = 1'b0; UseRtD = 1'b0;
        IsBrD = 1'b0; RegWriteE = 1'b0; MemToRegE = 1'b0; WriteRegE = '0;
        MemToRegM = 1'b0; WriteRegM = '0; MduStartE = 1'b0; MduIsDivE = 1'b0;
        MduReadD = 1'b0;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        int stalls, busy;
        logic [31:0] base;
        idle_inputs();
        rst = 1'b1;
        nxt(); nxt();
        #3;
        chk("rst_pcen", {31'd0, PCEn}, 32'd0);
        chk("rst_declr", {31'd0, DEClr}, 32'd1);
        rst = 1'b0;
        nxt();
        #3 chk("cnt_after_rst", StallCnt, 32'd0);

        // Load-use on rs
        nxt();
        MemToRegE = 1; RegWriteE = 1; WriteRegE = 5'd8; RsD = 5'd8; UseRsD = 1;
        #3;
        chk("lu_pcen", {31'd0, PCEn}, 32'd0);
        chk("lu_fden", {31'd0, FDEn}, 32'd0);
        chk("lu_declr", {31'd0, DEClr}, 32'd1);
        nxt();
        idle_inputs();
        #3 chk("lu_cnt", StallCnt, 32'd1);
        nxt();
        MemToRegE = 1; RegWriteE = 1; WriteRegE = 5'd0; RsD = 5'd0; UseRsD = 1;
        #3 chk("lu_r0_pcen", {31'd0, PCEn}, 32'd1);

        // Branch operand hazards
        nxt(); idle_inputs();
        IsBrD = 1; RtD = 5'd9; UseRtD = 1; MemToRegM = 1; WriteRegM = 5'd9;
        #3 chk("br_mem_pcen", {31'd0, PCEn}, 32'd0);
        nxt(); idle_inputs();
        IsBrD = 1; RtD = 5'd9; UseRtD = 1; RegWriteE = 1; WriteRegE = 5'd9;
        #3 chk("br_alu_pcen", {31'd0, PCEn}, 32'd0);
        nxt(); idle_inputs();
        IsBrD = 1; RtD = 5'd9; UseRtD = 1; RegWriteE = 1; WriteRegE = 5'd10;
        #3 chk("br_none_pcen", {31'd0, PCEn}, 32'd1);

        // Divide with a dependent read waiting in ID
        stalls = 0; busy = 0;
        for (int i = 0; i < 16; i++) begin
            nxt(); idle_inputs();
            MduReadD = 1;
            MduStartE = (i == 0); MduIsDivE = 1;
            #3;
            if (!PCEn) stalls++;
            if (MduBusy) busy++;
        end
        chk("div_stalls", stalls, 32'd11);
        chk("div_busy", busy, 32'd10);

        // Overlapping start during a multiply
        busy = 0;
        for (int i = 0; i < 12; i++) begin
            nxt(); idle_inputs();
            MduStartE = (i == 0 || i == 2);
            MduIsDivE = (i == 2);
            #3;
            if (MduBusy) busy++;
        end
        chk("ovl_busy", busy, 32'd5);
        chk("ovl_err", {31'd0, MduErr}, 32'd1);
        nxt(); idle_inputs();
        #3 chk("ovl_err_hold", {31'd0, MduErr}, 32'd1);

        // Fetch wait overlapping a load-use hazard
        base = StallCnt;
        for (int i = 0; i < 3; i++) begin
            nxt(); idle_inputs();
            ImemReady = 0;
            MemToRegE = 1; RegWriteE = 1; WriteRegE = 5'd4; RtD = 5'd4; UseRtD = 1;
        end
        nxt(); idle_inputs();
        #3;
        chk("fw_cnt", StallCnt - base, 32'd3);
        chk("fw_release", {31'd0, PCEn}, 32'd1);

        // Reset in the middle of a busy divide
        rst = 1; nxt(); rst = 0;
        for (int i = 0; i < 7; i++) begin
            nxt(); idle_inputs(); ImemReady = 0;
        end
        nxt(); idle_inputs(); MduStartE = 1; MduIsDivE = 1;
        nxt(); idle_inputs(); MduStartE = 1;
        nxt(); idle_inputs();
        #3;
        chk("pre_rst_cnt", StallCnt, 32'd7);
        chk("pre_rst_busy", {31'd0, MduBusy}, 32'd1);
        chk("pre_rst_err", {31'd0, MduErr}, 32'd1);
        rst = 1;
        #1;
        chk("in_rst_pcen", {31'd0, PCEn}, 32'd0);
        chk("in_rst_declr", {31'd0, DEClr}, 32'd1);
        nxt(); rst = 0;
        #3;
        chk("post_rst_busy", {31'd0, MduBusy}, 32'd0);
        chk("post_rst_cnt", StallCnt, 32'd0);
        chk("post_rst_err", {31'd0, MduErr}, 32'd0);

        // Saturation of the stall counter
        nxt(); idle_inputs();
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1 release dut.stall_cnt;
        sat_load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt(); sat_load = 1'b0; idle_inputs(); ImemReady = 0;
        end
        nxt(); idle_inputs();
        #3 chk("sat_cnt", StallCnt, 32'hFFFF_FFFF);

        // Randomized traffic
        rst = 1; nxt(); rst = 0;
        for (int i = 0; i < 3000; i++) begin
            nxt();
            rst       = ($urandom_range(0, 99) == 0);
            ImemReady = ($urandom_range(0, 5) != 0);
            RsD       = 5'($urandom_range(0, 3));
            RtD       = 5'($urandom_range(0, 3));
            UseRsD    = 1'($urandom);
            UseRtD    = 1'($urandom);
            IsBrD     = ($urandom_range(0, 3) == 0);
            RegWriteE = 1'($urandom);
            MemToRegE = ($urandom_range(0, 2) == 0);
            WriteRegE = 5'($urandom_range(0, 3));
            MemToRegM = ($urandom_range(0, 2) == 0);
            WriteRegM = 5'($urandom_range(0, 3));
            MduStartE = ($urandom_range(0, 7) == 0);
            MduIsDivE = 1'($urandom);
            MduReadD  = ($urandom_range(0, 2) == 0);
        end
        nxt(); rst = 0; idle_inputs();
        nxt(); nxt();
        #4;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
